peripheral_stepper_multi: RTL and testbench
===========================================

Name: peripheral_stepper_multi

Overview:
Parametrised multi-axis step/direction motion controller on the J1 I/O bus. It generalises the two-axis (theta/phi) motion peripheral to N_CH independent channels. Each channel has a register set, a signed 16-bit position counter, and a step-pulse FSM that drives the axis toward a programmed target at a programmed step period. Per-channel sticky done flags are combined into one interrupt line.

Parameters:
N_CH, 2, number of axes (1..8)
ADDR_W, 5, bus address width; addr[ADDR_W-1:2] = channel index, addr[1:0] = register select
PULSE_W, 4, step high time in clk cycles (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
d_in  in  16  write data
cs  in  1  peripheral select
addr  in  ADDR_W  register address (LSBs of j1_io_addr)
rd  in  1  read strobe
wr  in  1  write strobe
d_out  out  16  read data, registered
step  out  N_CH  step pulse per channel
dir  out  N_CH  direction per channel (1 = increasing position)
irq  out  1  OR over channels of (done & ie)

Behaviour:
- Reset (rst=0, async): all registers, counters and FSMs return to IDLE/0; d_out=0, step=0, dir=0, irq=0.
- Register map per channel c:
  - reg0 CTRL: bit0 en, bit3 ie (R/W); bit1 busy (RO); bit2 done (RO, sticky; a write with d_in[2]=1 clears it).
  - reg1 PERIOD: step period in cycles; effective period = max(PERIOD, 2*PULSE_W).
  - reg2 TARGET: signed target position (R/W).
  - reg3 POS: signed current position. Write presets it only when busy=0; the write is ignored while busy.
- Write: on the clk edge where cs&&wr, the selected register updates. A channel index >= N_CH is ignored.
- Read: when cs&&rd, d_out gets the selected register on the next edge (1-cycle latency). Otherwise d_out=0. An out-of-range channel reads 0. Unused CTRL bits read 0.
- FSM per channel: IDLE, SETUP, HIGH, LOW.
  - IDLE: if en && POS!=TARGET (signed compare), latch dir = (TARGET>POS), go SETUP, busy=1.
  - SETUP: 1 cycle. Holds dir stable before the step edge; step=0.
  - HIGH: step=1 for PULSE_W cycles. On exit, POS increments (dir=1) or decrements (dir=0) by 1.
  - LOW: step=0 for (effective period - PULSE_W) cycles. At the end:
    - if en && POS!=TARGET and the required dir equals the latched dir, go to HIGH;
    - if en && POS!=TARGET and the direction reverses, go to SETUP (dir updated);
    - otherwise go to IDLE, busy=0, and set done=1 if POS==TARGET.
- A TARGET or PERIOD write mid-move takes effect at the next decision point (end of LOW). An in-progress pulse/period is never truncated.
- Clearing en mid-move completes the current HIGH+LOW, then goes IDLE with done unchanged.
- If a done-clear write and a done-set event occur in the same cycle, the set wins.
- POS moves only toward TARGET, so no wrap occurs. A preset to 16'h7FFF with TARGET 16'h8000 moves down (signed compare).
- irq is combinational from registered done/ie bits. It is deasserted by clearing done or ie.

Test Plan:
- Reset with rst=0 mid-move (ch0 busy, step=1) -> step=0, dir=0, POS=0, busy=0, d_out=0 immediately, without waiting for a clk edge.
- ch0: PERIOD=20, TARGET=3, en=1 -> dir=1 one cycle before the first step rise; 3 pulses each 4 cycles high, with a 20-cycle rise-to-rise spacing; POS reads 3; CTRL reads done=1, busy=0.
- ch1: POS preset 10, TARGET=7, PERIOD=0, ie=1 -> dir=0; 3 pulses with an 8-cycle period (clamped); POS=7; irq=1; write CTRL with d_in=16'h000D -> irq=0.
- ch0 moving to 5, TARGET rewritten to 16'hFFFE at POS=2 -> current pulse completes; SETUP inserted with dir=0; POS ends at -2; done=1.
- Write POS=100 while busy -> ignored, POS unchanged; clear en mid-move -> current period completes, busy=0, done=0.
- Two channels run concurrently with different PERIODs -> independent step timing. Read of channel index 7 with N_CH=2 -> d_out=0 one cycle after rd; writes to it have no effect.

Source files
------------

// File: rtl/peripheral_stepper_multi.sv
// Multi-axis step/direction motion controller on the J1 I/O bus.
// Each channel runs its own IDLE/SETUP/HIGH/LOW pulse FSM toward a signed target.
module peripheral_stepper_multi #(
    parameter int N_CH    = 2,
    parameter int ADDR_W  = 5,
    parameter int PULSE_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       d_in,
    input  logic              cs,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rd,
    input  logic              wr,
    output logic [15:0]       d_out,
    output logic [N_CH-1:0]   step,
    output logic [N_CH-1:0]   dir,
    output logic              irq
);

    localparam int          CH_W    = ADDR_W - 2;
    localparam logic [15:0] PW      = 16'(PULSE_W);
    localparam logic [15:0] MIN_PER = 16'(2 * PULSE_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW
    } st_t;

    logic [CH_W-1:0] ch_sel;
    logic [1:0]      reg_sel;
    logic            ch_ok;
    logic            bus_wr;
    logic [15:0]     rd_mux;

    logic [15:0]     ctrl_v [N_CH];
    logic [15:0]     per_v  [N_CH];
    logic [15:0]     tgt_v  [N_CH];
    logic [15:0]     pos_v  [N_CH];
    logic [N_CH-1:0] irq_v;

    assign ch_sel  = addr[ADDR_W-1:2];
    assign reg_sel = addr[1:0];
    assign ch_ok   = 32'(ch_sel) < 32'(N_CH);
    assign bus_wr  = cs && wr;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        st_t         st, st_nx;
        logic        en_q, ie_q, done_q, dir_q, dir_nx;
        logic        done_set, pos_step, sel, want, up;
        logic [15:0] per_q, tgt_q, pos_q;
        logic [15:0] cnt, cnt_nx, low_len, low_nx, eff, low_new;

        assign sel     = bus_wr && ch_ok && (32'(ch_sel) == 32'(c));
        assign want    = en_q && (pos_q != tgt_q);
        assign up      = $signed(tgt_q) > $signed(pos_q);
        assign eff     = (per_q > MIN_PER) ? per_q : MIN_PER;
        assign low_new = eff - PW;

        // LOW length is latched at decision points so a PERIOD write
        // never stretches or truncates the period already in flight.
        always_comb begin
            st_nx    = st;
            cnt_nx   = cnt;
            dir_nx   = dir_q;
            low_nx   = low_len;
            pos_step = 1'b0;
            done_set = 1'b0;
            unique case (st)
                S_IDLE: begin
                    if (want) begin
                        st_nx  = S_SETUP;
                        dir_nx = up;
                        low_nx = low_new;
                    end
                end
                S_SETUP: begin
                    st_nx  = S_HIGH;
                    cnt_nx = PW - 16'd1;
                end
                S_HIGH: begin
                    if (cnt == 16'd0) begin
                        st_nx    = S_LOW;
                        cnt_nx   = low_len - 16'd1;
                        pos_step = 1'b1;
                    end else begin
                        cnt_nx = cnt - 16'd1;
                    end
                end
                S_LOW: begin
                    if (cnt != 16'd0) begin
                        cnt_nx = cnt - 16'd1;
                    end else if (want && (up == dir_q)) begin
                        st_nx  = S_HIGH;
                        cnt_nx = PW - 16'd1;
                        low_nx = low_new;
                    end else if (want) begin
                        st_nx  = S_SETUP;
                        dir_nx = up;
                        low_nx = low_new;
                    end else begin
                        st_nx    = S_IDLE;
                        done_set = (pos_q == tgt_q);
                    end
                end
            endcase
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                st      <= S_IDLE;
                cnt     <= '0;
                dir_q   <= 1'b0;
                low_len <= '0;
            end else begin
                st      <= st_nx;
                cnt     <= cnt_nx;
                dir_q   <= dir_nx;
                low_len <= low_nx;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                en_q   <= 1'b0;
                ie_q   <= 1'b0;
                done_q <= 1'b0;
                per_q  <= '0;
                tgt_q  <= '0;
                pos_q  <= '0;
            end else begin
                if (sel) begin
                    unique case (reg_sel)
                        2'd0: begin
                            en_q <= d_in[0];
                            ie_q <= d_in[3];
                        end
                        2'd1: per_q <= d_in;
                        2'd2: tgt_q <= d_in;
                        2'd3: if (st == S_IDLE) pos_q <= d_in;
                    endcase
                end
                if (pos_step) begin
                    pos_q <= dir_q ? pos_q + 16'd1 : pos_q - 16'd1;
                end
                if (done_set) begin
                    done_q <= 1'b1;
                end else if (sel && (reg_sel == 2'd0) && d_in[2]) begin
                    done_q <= 1'b0;
                end
            end
        end

        assign step[c]   = (st == S_HIGH);
        assign dir[c]    = dir_q;
        assign irq_v[c]  = done_q & ie_q;
        assign ctrl_v[c] = {12'd0, ie_q, done_q, st != S_IDLE, en_q};
        assign per_v[c]  = per_q;
        assign tgt_v[c]  = tgt_q;
        assign pos_v[c]  = pos_q;
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (int'(ch_sel) == i) begin
                unique case (reg_sel)
                    2'd0: rd_mux = ctrl_v[i];
                    2'd1: rd_mux = per_v[i];
                    2'd2: rd_mux = tgt_v[i];
                    2'd3: rd_mux = pos_v[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_out <= '0;
        end else if (cs && rd) begin
            d_out <= rd_mux;
        end else begin
            d_out <= '0;
        end
    end

    assign irq = |irq_v;

endmodule

// File: tb/tb_peripheral_stepper_multi.sv
// Bench for peripheral_stepper_multi: bus reads scored through a queue,
// step pulses timed by a negedge monitor.
module tb_peripheral_stepper_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] d_in = '0;
    logic        cs = 1'b0;
    logic [4:0]  addr = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] d_out;
    logic [1:0]  step;
    logic [1:0]  dir;
    logic        irq;

    peripheral_stepper_multi #(
        .N_CH   (2),
        .ADDR_W (5),
        .PULSE_W(4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .d_in (d_in),
        .cs   (cs),
        .addr (addr),
        .rd   (rd),
        .wr   (wr),
        .d_out(d_out),
        .step (step),
        .dir  (dir),
        .irq  (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    int          rise0[$], rise1[$], hi0[$], hi1[$];
    logic        rdir0[$], rdir1[$];
    logic [1:0]  sp = '0;
    logic [1:0]  dp = '0;
    int          hc0 = 0;
    int          hc1 = 0;

    always @(negedge clk) begin
        if (step[0] && !sp[0]) begin
            rise0.push_back(cyc);
            rdir0.push_back(dp[0]);
        end
        if (step[0]) hc0 <= hc0 + 1;
        else if (sp[0]) begin
            hi0.push_back(hc0);
            hc0 <= 0;
        end
        if (step[1] && !sp[1]) begin
            rise1.push_back(cyc);
            rdir1.push_back(dp[1]);
        end
        if (step[1]) hc1 <= hc1 + 1;
        else if (sp[1]) begin
            hi1.push_back(hc1);
            hc1 <= 0;
        end
        sp <= step;
        dp <= dir;
    end

    logic [15:0] exp_q[$];
    string       tag_q[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clr_mon();
        rise0.delete();
        rise1.delete();
        hi0.delete();
        hi1.delete();
        rdir0.delete();
        rdir1.delete();
    endtask

    task automatic bus_wr(input int ch, input int r, input logic [15:0] data);
        @(negedge clk);
        cs   = 1'b1;
        wr   = 1'b1;
        addr = {3'(ch), 2'(r)};
        d_in = data;
        @(negedge clk);
        cs   = 1'b0;
        wr   = 1'b0;
        d_in = '0;
    endtask

    task automatic bus_rd(input int ch, input int r, input logic [15:0] exp,
                          input string tag);
        @(negedge clk);
        cs   = 1'b1;
        rd   = 1'b1;
        addr = {3'(ch), 2'(r)};
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        cs = 1'b0;
        rd = 1'b0;
        chk(tag_q.pop_front(), d_out, exp_q.pop_front());
    endtask

    task automatic wait_rises(input int ch, input int n, input int budget,
                              input string tag);
        int k = 0;
        while (((ch == 0) ? rise0.size() : rise1.size()) < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, (ch == 0) ? rise0.size() : rise1.size(), n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_step", step, 0);
        chk("rst_dir", dir, 0);
        chk("rst_irq", irq, 0);
        chk("rst_dout", d_out, 0);
        bus_rd(0, 0, 16'h0000, "rst_ctrl0");
        bus_rd(1, 3, 16'h0000, "rst_pos1");

        // ch0 straight move to +3
        clr_mon();
        bus_wr(0, 1, 16'd20);
        bus_wr(0, 2, 16'd3);
        bus_wr(0, 0, 16'h0001);
        wait_rises(0, 3, 100, "t2_rises");
        repeat (30) @(negedge clk);
        chk("t2_rises_final", rise0.size(), 3);
        chk("t2_dir_setup", rdir0[0], 1);
        for (int i = 0; i < hi0.size(); i++) chk("t2_hi", hi0[i], 4);
        for (int i = 1; i < rise0.size(); i++)
            chk("t2_space", rise0[i] - rise0[i-1], 20);
        bus_rd(0, 3, 16'd3, "t2_pos");
        bus_rd(0, 0, 16'h0005, "t2_ctrl");
        chk("t2_irq", irq, 0);

        // ch1 down move with clamped period and interrupt
        clr_mon();
        bus_wr(1, 3, 16'd10);
        bus_wr(1, 2, 16'd7);
        bus_wr(1, 1, 16'd0);
        bus_wr(1, 0, 16'h0009);
        wait_rises(1, 3, 60, "t3_rises");
        repeat (20) @(negedge clk);
        chk("t3_rises_final", rise1.size(), 3);
        chk("t3_dir", dir[1], 0);
        for (int i = 0; i < hi1.size(); i++) chk("t3_hi", hi1[i], 4);
        for (int i = 1; i < rise1.size(); i++)
            chk("t3_space", rise1[i] - rise1[i-1], 8);
        bus_rd(1, 3, 16'd7, "t3_pos");
        chk("t3_irq_set", irq, 1);
        bus_rd(1, 0, 16'h000D, "t3_ctrl");
        bus_wr(1, 0, 16'h000D);
        @(negedge clk);
        chk("t3_irq_clr", irq, 0);
        bus_rd(1, 0, 16'h0009, "t3_ctrl_clr");

        // ch0 retarget across zero mid-move
        bus_wr(0, 0, 16'h0004);
        bus_wr(0, 3, 16'd0);
        bus_wr(0, 2, 16'd5);
        clr_mon();
        bus_wr(0, 0, 16'h0001);
        wait_rises(0, 2, 80, "t4_rises2");
        repeat (6) @(negedge clk);
        bus_wr(0, 2, 16'hFFFE);
        wait_rises(0, 6, 200, "t4_rises6");
        repeat (30) @(negedge clk);
        chk("t4_rises_final", rise0.size(), 6);
        if (rise0.size() == 6) begin
            chk("t4_sp1", rise0[1] - rise0[0], 20);
            chk("t4_sp2", rise0[2] - rise0[1], 21);
            chk("t4_sp3", rise0[3] - rise0[2], 20);
            chk("t4_rev_dir", rdir0[2], 0);
        end
        for (int i = 0; i < hi0.size(); i++) chk("t4_hi", hi0[i], 4);
        chk("t4_dir", dir[0], 0);
        bus_rd(0, 3, 16'hFFFE, "t4_pos");
        bus_rd(0, 0, 16'h0005, "t4_ctrl");

        // preset while busy, then disable mid-move
        clr_mon();
        bus_wr(0, 2, 16'd10);
        bus_wr(0, 0, 16'h0005);
        wait_rises(0, 1, 40, "t5_rise");
        repeat (6) @(negedge clk);
        bus_wr(0, 3, 16'd100);
        bus_rd(0, 3, 16'hFFFF, "t5_pos_busy");
        bus_wr(0, 0, 16'h0000);
        repeat (30) @(negedge clk);
        chk("t5_rises", rise0.size(), 1);
        chk("t5_step", step[0], 0);
        bus_rd(0, 0, 16'h0000, "t5_ctrl");
        bus_rd(0, 3, 16'hFFFF, "t5_pos");

        // two channels concurrently
        clr_mon();
        bus_wr(1, 1, 16'd10);
        bus_wr(1, 2, 16'd11);
        bus_wr(0, 3, 16'd0);
        bus_wr(0, 2, 16'd4);
        bus_wr(0, 1, 16'd12);
        bus_wr(0, 0, 16'h0001);
        wait_rises(0, 4, 120, "t6_rises0");
        wait_rises(1, 4, 120, "t6_rises1");
        repeat (30) @(negedge clk);
        chk("t6_n0", rise0.size(), 4);
        chk("t6_n1", rise1.size(), 4);
        for (int i = 1; i < rise0.size(); i++)
            chk("t6_space0", rise0[i] - rise0[i-1], 12);
        for (int i = 1; i < rise1.size(); i++)
            chk("t6_space1", rise1[i] - rise1[i-1], 10);
        for (int i = 0; i < hi1.size(); i++) chk("t6_hi1", hi1[i], 4);
        bus_rd(0, 3, 16'd4, "t6_pos0");
        bus_rd(1, 3, 16'd11, "t6_pos1");
        bus_rd(1, 0, 16'h000D, "t6_ctrl1");
        chk("t6_irq", irq, 1);

        // out-of-range channel
        bus_wr(7, 2, 16'h1234);
        bus_wr(7, 0, 16'h0009);
        bus_rd(7, 2, 16'h0000, "oor_tgt");
        bus_rd(7, 0, 16'h0000, "oor_ctrl");
        bus_rd(1, 2, 16'd11, "oor_alias1");
        bus_rd(0, 2, 16'd4, "oor_alias0");
        bus_rd(0, 0, 16'h0005, "oor_ctrl0");

        // async reset mid-pulse
        clr_mon();
        bus_wr(0, 2, 16'd50);
        @(negedge clk);
        cs   = 1'b1;
        rd   = 1'b1;
        addr = {3'd0, 2'd2};
        for (int k = 0; k < 40 && !step[0]; k++) @(negedge clk);
        chk("ar_pre_step", step[0], 1);
        chk("ar_pre_dout", d_out, 16'd50);
        chk("ar_pre_dir", dir[0], 1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_step", step, 0);
        chk("ar_dir", dir, 0);
        chk("ar_dout", d_out, 0);
        chk("ar_irq", irq, 0);
        cs = 1'b0;
        rd = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        bus_rd(0, 3, 16'h0000, "ar_pos0");
        bus_rd(0, 0, 16'h0000, "ar_ctrl0");
        bus_rd(1, 3, 16'h0000, "ar_pos1");
        repeat (5) @(negedge clk);
        chk("ar_idle_step", step, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
